// File: rtl/sweep_pkg.sv
// Shared types and constants for the gate-level sweep sequencers.
package sweep_pkg;

  localparam int SETTLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter used to hold a vector stable before sampling.
module settle_timer
  import sweep_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic                en_i,
  input  logic [SETTLE_W-1:0] load_val_i,
  output logic                zero_o
);

  logic [SETTLE_W-1:0] count_q;
  logic [SETTLE_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/sop_pos_sweep_checker.sv
// Exhaustive sweep of an SOP/POS function pair: captures both truth tables,
// counts disagreements and reports pass/fail.
module sop_pos_sweep_checker
  import sweep_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic [N_IN-1:0]      vec,
  input  logic                 f_min,
  input  logic                 f_max,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        mismatch_cnt,
  output logic [N_IN-1:0]      first_fail,
  output logic                 fail_valid,
  output logic [(2**N_IN)-1:0] tt_min,
  output logic [(2**N_IN)-1:0] tt_max
);

  localparam int N_VEC = 2 ** N_IN;
  // The timer counts down to zero inclusive, so SETTLE cycles need SETTLE-1.
  localparam logic [SETTLE_W-1:0] TMR_LOAD =
    (SETTLE == 0) ? '0 : SETTLE_W'(SETTLE - 1);

  state_t            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [N_IN:0]     cnt_q, cnt_d;
  logic [N_IN-1:0]   ff_q, ff_d;
  logic              fv_q, fv_d;
  logic              pass_q, pass_d;
  logic [N_VEC-1:0]  ttmin_q, ttmin_d;
  logic [N_VEC-1:0]  ttmax_q, ttmax_d;
  logic              tmr_load, tmr_en, tmr_zero;

  settle_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .en_i       (tmr_en),
    .load_val_i (TMR_LOAD),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    ff_d     = ff_q;
    fv_d     = fv_q;
    pass_d   = pass_q;
    ttmin_d  = ttmin_q;
    ttmax_d  = ttmax_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          vec_d   = '0;
          cnt_d   = '0;
          ff_d    = '0;
          fv_d    = 1'b0;
          pass_d  = 1'b0;
          ttmin_d = '0;
          ttmax_d = '0;
          if (SETTLE == 0) begin
            state_d = ST_SAMPLE;
          end else begin
            state_d  = ST_SETTLE;
            tmr_load = 1'b1;
          end
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
          pass_d  = 1'b0;
        end else if (tmr_zero) begin
          state_d = ST_SAMPLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          state_d = ST_IDLE;
          pass_d  = 1'b0;
        end else begin
          ttmin_d[vec_q] = f_min;
          ttmax_d[vec_q] = f_max;
          if (f_min != f_max) begin
            cnt_d = cnt_q + (N_IN+1)'(1);
            if (!fv_q) begin
              ff_d = vec_q;
              fv_d = 1'b1;
            end
          end
          if (vec_q == {N_IN{1'b1}}) begin
            state_d = ST_DONE;
          end else begin
            vec_d = vec_q + N_IN'(1);
            if (SETTLE != 0) begin
              state_d  = ST_SETTLE;
              tmr_load = 1'b1;
            end
          end
        end
      end
      ST_DONE: begin
        pass_d  = (cnt_q == '0);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      ff_q    <= '0;
      fv_q    <= 1'b0;
      pass_q  <= 1'b0;
      ttmin_q <= '0;
      ttmax_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      ff_q    <= ff_d;
      fv_q    <= fv_d;
      pass_q  <= pass_d;
      ttmin_q <= ttmin_d;
      ttmax_q <= ttmax_d;
    end
  end

  assign vec          = vec_q;
  assign busy         = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign done         = (state_q == ST_DONE);
  assign pass         = pass_q;
  assign mismatch_cnt = cnt_q;
  assign first_fail   = ff_q;
  assign fail_valid   = fv_q;
  assign tt_min       = ttmin_q;
  assign tt_max       = ttmax_q;

endmodule

// File: tb/tb_sop_pos_sweep_checker.sv
// Scoreboard bench: three checker instances (3-in/settle 0, 3-in/settle 2, 4-in/settle 1).
module tb_sop_pos_sweep_checker;

  logic clk = 1'b0;
  logic rst_n;
  logic abort;
  logic startA, startB, startC;
  int   modeC;

  logic [2:0]  vecA, ffA, vecB, ffB;
  logic [3:0]  vecC, ffC;
  logic [3:0]  cntA, cntB;
  logic [4:0]  cntC;
  logic [7:0]  ttMinA, ttMaxA, ttMinB, ttMaxB;
  logic [15:0] ttMinC, ttMaxC;
  logic        busyA, doneA, passA, fvA, fMinA, fMaxA;
  logic        busyB, doneB, passB, fvB, fMinB, fMaxB;
  logic        busyC, doneC, passC, fvC, fMinC, fMaxC;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] ttMin;
    logic [63:0] ttMax;
    int          cnt;
    int          firstFail;
    bit          failValid;
    bit          pass;
  } expRec_t;

  expRec_t expQ[$];

  logic [63:0] oVec, oTtMin, oTtMax, oCnt, oFf;
  logic        oFv, oPass, oDone, oBusy;

  always #5 clk = ~clk;

  // Reference functions: a=vec[2], b=vec[1], c=vec[0] for the 3-input pair.
  function automatic logic fMin3(input logic [2:0] v);
    return (!v[2] && !v[1]) || (!v[1] && v[0]) || (v[1] && !v[0]);
  endfunction

  function automatic logic fMax3(input logic [2:0] v);
    return (!v[2] || v[1] || v[0]) && (!v[1] || !v[0]);
  endfunction

  function automatic logic fBase4(input logic [3:0] v);
    return (v[3] ^ v[0]) || (v[2] && v[1]);
  endfunction

  function automatic logic fMin4(input logic [3:0] v, input int mode);
    return (mode == 3) ? 1'b0 : fBase4(v);
  endfunction

  function automatic logic fMax4(input logic [3:0] v, input int mode);
    case (mode)
      1:       return fBase4(v) ^ (v == 4'd5);
      2:       return fBase4(v) ^ ((v == 4'd5) || (v == 4'd12));
      3:       return 1'b1;
      default: return fBase4(v);
    endcase
  endfunction

  assign fMinA = fMin3(vecA);
  assign fMaxA = fMax3(vecA);
  assign fMinB = fMin3(vecB);
  assign fMaxB = fMax3(vecB);
  assign fMinC = fMin4(vecC, modeC);
  assign fMaxC = fMax4(vecC, modeC);

  sop_pos_sweep_checker #(.N_IN(3), .SETTLE(0)) uDutA (
    .clk(clk), .rst_n(rst_n), .start(startA), .abort(abort), .vec(vecA),
    .f_min(fMinA), .f_max(fMaxA), .busy(busyA), .done(doneA), .pass(passA),
    .mismatch_cnt(cntA), .first_fail(ffA), .fail_valid(fvA),
    .tt_min(ttMinA), .tt_max(ttMaxA)
  );

  sop_pos_sweep_checker #(.N_IN(3), .SETTLE(2)) uDutB (
    .clk(clk), .rst_n(rst_n), .start(startB), .abort(abort), .vec(vecB),
    .f_min(fMinB), .f_max(fMaxB), .busy(busyB), .done(doneB), .pass(passB),
    .mismatch_cnt(cntB), .first_fail(ffB), .fail_valid(fvB),
    .tt_min(ttMinB), .tt_max(ttMaxB)
  );

  sop_pos_sweep_checker #(.N_IN(4), .SETTLE(1)) uDutC (
    .clk(clk), .rst_n(rst_n), .start(startC), .abort(abort), .vec(vecC),
    .f_min(fMinC), .f_max(fMaxC), .busy(busyC), .done(doneC), .pass(passC),
    .mismatch_cnt(cntC), .first_fail(ffC), .fail_valid(fvC),
    .tt_min(ttMinC), .tt_max(ttMaxC)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic sampleDut(input int which);
    case (which)
      0: begin
        oVec = 64'(vecA); oTtMin = 64'(ttMinA); oTtMax = 64'(ttMaxA);
        oCnt = 64'(cntA); oFf = 64'(ffA); oFv = fvA; oPass = passA;
        oDone = doneA; oBusy = busyA;
      end
      1: begin
        oVec = 64'(vecB); oTtMin = 64'(ttMinB); oTtMax = 64'(ttMaxB);
        oCnt = 64'(cntB); oFf = 64'(ffB); oFv = fvB; oPass = passB;
        oDone = doneB; oBusy = busyB;
      end
      default: begin
        oVec = 64'(vecC); oTtMin = 64'(ttMinC); oTtMax = 64'(ttMaxC);
        oCnt = 64'(cntC); oFf = 64'(ffC); oFv = fvC; oPass = passC;
        oDone = doneC; oBusy = busyC;
      end
    endcase
  endtask

  task automatic setStart(input int which, input logic v);
    case (which)
      0:       startA = v;
      1:       startB = v;
      default: startC = v;
    endcase
  endtask

  task automatic checkAllZero(input int which, input string tag);
    sampleDut(which);
    checkOutput({tag, ".vec"}, oVec, 0);
    checkOutput({tag, ".busy"}, 64'(oBusy), 0);
    checkOutput({tag, ".done"}, 64'(oDone), 0);
    checkOutput({tag, ".pass"}, 64'(oPass), 0);
    checkOutput({tag, ".cnt"}, oCnt, 0);
    checkOutput({tag, ".firstFail"}, oFf, 0);
    checkOutput({tag, ".failValid"}, 64'(oFv), 0);
    checkOutput({tag, ".ttMin"}, oTtMin, 0);
    checkOutput({tag, ".ttMax"}, oTtMax, 0);
  endtask

  task automatic pushExpected(input int which);
    expRec_t r;
    int      nv;
    logic    fm, fx;
    nv = (which == 2) ? 16 : 8;
    r.ttMin = '0; r.ttMax = '0; r.cnt = 0; r.firstFail = 0;
    r.failValid = 1'b0; r.pass = 1'b0;
    for (int k = 0; k < nv; k++) begin
      if (which == 2) begin
        fm = fMin4(4'(k), modeC);
        fx = fMax4(4'(k), modeC);
      end else begin
        fm = fMin3(3'(k));
        fx = fMax3(3'(k));
      end
      r.ttMin[k] = fm;
      r.ttMax[k] = fx;
      if (fm != fx) begin
        if (!r.failValid) r.firstFail = k;
        r.failValid = 1'b1;
        r.cnt++;
      end
    end
    r.pass = (r.cnt == 0);
    expQ.push_back(r);
  endtask

  // Full sweep: push the expectation, pulse start, follow the sweep, pop at done.
  task automatic applyStimulus(input int which, input string tag);
    expRec_t r;
    int      s, nv, expCyc, cyc, busyCnt, badRun, run, prevVec;
    s      = (which == 0) ? 0 : (which == 1) ? 2 : 1;
    nv     = (which == 2) ? 16 : 8;
    expCyc = nv * (s + 1);
    pushExpected(which);
    setStart(which, 1'b1);
    @(negedge clk);
    setStart(which, 1'b0);
    sampleDut(which);
    checkOutput({tag, ".vecStart"}, oVec, 0);
    cyc = 0; busyCnt = 0; badRun = 0; run = 0; prevVec = int'(oVec);
    while (!oDone && cyc < 400) begin
      if (oBusy) busyCnt++;
      if (int'(oVec) != prevVec) begin
        if (run != s + 1 || int'(oVec) != prevVec + 1) badRun++;
        run = 0;
        prevVec = int'(oVec);
      end
      run++;
      @(negedge clk);
      cyc++;
      sampleDut(which);
    end
    if (run != s + 1) badRun++;
    checkOutput({tag, ".doneSeen"}, 64'(oDone), 1);
    checkOutput({tag, ".sweepCycles"}, 64'(cyc), 64'(expCyc));
    checkOutput({tag, ".busyCycles"}, 64'(busyCnt), 64'(expCyc));
    checkOutput({tag, ".vecRuns"}, 64'(badRun), 0);
    checkOutput({tag, ".busyInDone"}, 64'(oBusy), 0);
    checkOutput({tag, ".vecHold"}, oVec, 64'(nv - 1));
    if (expQ.size() == 0) begin
      checkOutput({tag, ".queueEmpty"}, 1, 0);
    end else begin
      r = expQ.pop_front();
      checkOutput({tag, ".ttMin"}, oTtMin, r.ttMin);
      checkOutput({tag, ".ttMax"}, oTtMax, r.ttMax);
      checkOutput({tag, ".cnt"}, oCnt, 64'(r.cnt));
      checkOutput({tag, ".firstFail"}, oFf, 64'(r.firstFail));
      checkOutput({tag, ".failValid"}, 64'(oFv), 64'(r.failValid));
      @(negedge clk);
      sampleDut(which);
      checkOutput({tag, ".donePulse"}, 64'(oDone), 0);
      checkOutput({tag, ".pass"}, 64'(oPass), 64'(r.pass));
    end
  endtask

  task automatic waitVecC(input int target, input string tag);
    int cyc;
    cyc = 0;
    while (vecC != 4'(target) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, ".reachVec"}, 64'(vecC), 64'(target));
  endtask

  initial begin
    logic [15:0] partTt;
    int          doneCount;
    rst_n = 1'b0; abort = 1'b0; modeC = 0;
    startA = 1'b0; startB = 1'b0; startC = 1'b0;
    repeat (2) @(negedge clk);
    for (int w = 0; w < 3; w++) checkAllZero(w, "reset");
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(0, "sweepA");
    checkOutput("sweepA.ttMinConst", 64'(ttMinA), 64'h67);
    checkOutput("sweepA.ttMaxConst", 64'(ttMaxA), 64'h67);
    applyStimulus(1, "sweepB");

    modeC = 1;
    applyStimulus(2, "oneFlip");
    checkOutput("oneFlip.cntConst", 64'(cntC), 1);
    checkOutput("oneFlip.ffConst", 64'(ffC), 5);
    modeC = 2;
    applyStimulus(2, "twoFlip");
    checkOutput("twoFlip.cntConst", 64'(cntC), 2);
    modeC = 3;
    applyStimulus(2, "allDiffer");
    checkOutput("allDiffer.cntConst", 64'(cntC), 64'h10);
    checkOutput("allDiffer.ttMaxConst", 64'(ttMaxC), 64'hFFFF);
    modeC = 0;
    applyStimulus(2, "clean4");

    // Abort while vector 3 is settling, then start+abort together in IDLE.
    partTt = '0;
    for (int k = 0; k < 3; k++) partTt[k] = fBase4(4'(k));
    setStart(2, 1'b1);
    @(negedge clk);
    setStart(2, 1'b0);
    waitVecC(3, "abort");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort.busy", 64'(busyC), 0);
    checkOutput("abort.done", 64'(doneC), 0);
    checkOutput("abort.pass", 64'(passC), 0);
    checkOutput("abort.ttMin", 64'(ttMinC), 64'(partTt));
    checkOutput("abort.ttMax", 64'(ttMaxC), 64'(partTt));
    setStart(2, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    setStart(2, 1'b0);
    abort = 1'b0;
    doneCount = 0;
    checkOutput("bothIdle.busy", 64'(busyC), 0);
    checkOutput("bothIdle.ttKept", 64'(ttMinC), 64'(partTt));
    repeat (4) begin
      @(negedge clk);
      if (doneC || busyC) doneCount++;
    end
    checkOutput("bothIdle.stayIdle", 64'(doneCount), 0);

    // Reset in the middle of a sweep, then a clean sweep afterwards.
    setStart(2, 1'b1);
    @(negedge clk);
    setStart(2, 1'b0);
    waitVecC(6, "midReset");
    rst_n = 1'b0;
    #1;
    checkAllZero(2, "midReset");
    doneCount = 0;
    repeat (3) begin
      @(negedge clk);
      if (doneC) doneCount++;
    end
    checkOutput("midReset.noDone", 64'(doneCount), 0);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(2, "afterReset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sop_pos_sweep_checker.md
Name: sop_pos_sweep_checker

Overview:
Sequencer that exhaustively drives an N-input Boolean function pair and checks it.
- The pair is a minterm (SOP) gate network and a maxterm (POS) gate network under test, both combinational.
- It steps through all 2^N input vectors, waits a programmable settle time, then samples both outputs.
- It captures both truth tables, counts disagreements and reports pass/fail with a start/done handshake.
- It sits between a bench or host and the gate-level function modules, replacing hand-written per-vector stimulus.

Parameters:
N_IN, 4, number of function inputs; legal range 1..6. vec[N_IN-1] is input a (MSB).
SETTLE, 1, idle cycles after a vector is applied before sampling; legal range 0..15.

Ports:
clk  input  1  Clock. The block has one clock; reset is asynchronous and active-low.
rst_n  input  1  Active-low asynchronous reset.
start  input  1  Begin a sweep. Sampled only in IDLE.
abort  input  1  Synchronous cancel of a sweep in progress.
vec  output  N_IN  Input vector driven to both functions under test.
f_min  input  1  Output of the SOP implementation.
f_max  input  1  Output of the POS implementation.
busy  output  1  High from the cycle after start is accepted until the sweep ends.
done  output  1  One-cycle pulse when a sweep completes normally.
pass  output  1  1 when the last completed sweep had zero mismatches; held until the next start.
mismatch_cnt  output  N_IN+1  Count of vectors where f_min != f_max.
first_fail  output  N_IN  Lowest vector index that mismatched.
fail_valid  output  1  first_fail is meaningful.
tt_min  output  2^N_IN  Captured SOP truth table; bit k = f_min at vec = k.
tt_max  output  2^N_IN  Captured POS truth table; bit k = f_max at vec = k.

Behaviour:
- Reset (async assert): state IDLE; vec, busy, done, pass, mismatch_cnt, first_fail, fail_valid, tt_min and tt_max all 0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 and abort=0 -> go to SETTLE (or to SAMPLE if SETTLE=0).
  - On that transition: clear vec, mismatch_cnt, fail_valid, first_fail, tt_min, tt_max and pass.
  - busy is high from the next cycle.
- SETTLE: holds vec stable for exactly SETTLE cycles using a down-counter, then goes to SAMPLE.
- SAMPLE (1 cycle, vec still stable):
  - Write tt_min[vec] <= f_min and tt_max[vec] <= f_max.
  - If f_min != f_max: increment mismatch_cnt; if fail_valid=0, set first_fail <= vec and fail_valid <= 1.
  - If vec == 2^N_IN-1, go to DONE. Otherwise vec <= vec+1 and go to SETTLE (or stay in SAMPLE if SETTLE=0).
- DONE (1 cycle):
  - done=1; pass <= (mismatch_cnt==0); busy deasserts; next state IDLE.
  - vec holds its last value.
- Timing:
  - Each vector occupies exactly SETTLE+1 cycles.
  - The sweep (busy high) lasts 2^N_IN*(SETTLE+1) cycles plus 1 DONE cycle.
- Sampling uses the inputs as seen at the SAMPLE clock edge. The functions under test are purely combinational, with no further latency.
- start while busy: ignored.
- abort in SETTLE or SAMPLE:
  - Next state IDLE, busy=0, no done pulse, pass=0.
  - Partial tt_min, tt_max, mismatch_cnt and first_fail retained.
  - A SAMPLE cycle coinciding with abort is not recorded.
- start and abort together in IDLE: abort wins; stay IDLE.
- abort in DONE: ignored; done still pulses.
- mismatch_cnt width N_IN+1 holds the maximum 2^N_IN without overflow.
- Reset asserted mid-sweep: immediate return to the reset state; no done pulse.

Decomposition:
- Shared package sweep_pkg holds:
  - the state typedef (IDLE, SETTLE, SAMPLE, DONE);
  - localparam N_VEC = 2^N_IN, computed in the module from the parameter;
  - the SETTLE width constant (4 bits).
- One sub-module, settle_timer: loadable 4-bit down-counter with load, enable and zero flag. It is reused by later gate-level sequencers.

Test Plan:
- N_IN=3, SETTLE=0, bench models f_min=!a!b+!bc+b!c and f_max=(!a+b+c)(!b+!c), start pulse -> done after 9 cycles, tt_min=tt_max=8'h67, mismatch_cnt=0, pass=1, fail_valid=0.
- N_IN=3, SETTLE=2, same functions -> busy high exactly 24 cycles, vec stable 3 cycles per value, done one cycle, pass=1.
- N_IN=4, f_max = f_min XOR (vec==5), or separately XOR (vec==5 or vec==12) -> mismatch_cnt=1 or 2 respectively, first_fail=5, fail_valid=1, pass=0.
- N_IN=4, f_min=0, f_max=1 -> mismatch_cnt=16 (5'b10000), first_fail=0, tt_min=16'h0000, tt_max=16'hFFFF, pass=0.
- Abort at vec=3 with SETTLE=1; then start and abort together in IDLE -> no done pulse, busy=0 the next cycle, pass=0, tt bits 0..2 kept; the simultaneous start is ignored and the state stays IDLE.
- rst_n low mid-sweep at vec=6, then release and start -> all outputs 0 during reset; the new sweep begins at vec=0 and completes normally with pass=1.
